// File: rtl/aw_slave_issue.sv
// AW issue stage between the upstream AW FIFO read side and an AXI slave port.
// Optional outstanding-transaction limit enabled by defining AW_SLAVE_OUTSTANDING_LIMIT_EN.
module aw_slave_issue #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_rempty,
  input  logic [48:0] fifo_rdata,
  output logic        fifo_rpop,
  output logic [7:0]  AWID_S,
  output logic [31:0] AWADDR_S,
  output logic [3:0]  AWLEN_S,
  output logic [2:0]  AWSIZE_S,
  output logic [1:0]  AWBURST_S,
  output logic        AWVALID_S,
  input  logic        AWREADY_S,
  input  logic        BVALID_S,
  input  logic        BREADY_S,
  output logic [2:0]  outstanding,
  output logic        aw_err
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [48:0] r_payload;
  logic        r_awErr;
  logic        w_creditOk;
  logic        w_awHs;
  logic        w_load;
  logic        w_underflow;

  assign w_awHs = (r_state == ISSUE) && AWREADY_S;

`ifdef AW_SLAVE_OUTSTANDING_LIMIT_EN
  logic [2:0] r_outstanding;
  logic       w_bHs;
  logic [3:0] w_inFlight;

  assign w_bHs       = BVALID_S && BREADY_S;
  // The transaction sitting in the slot already holds a credit.
  assign w_inFlight  = {1'b0, r_outstanding} + {3'b000, (r_state == ISSUE)};
  assign w_creditOk  = w_inFlight < 4'(MAX_OUTSTANDING);
  assign w_underflow = w_bHs && (r_outstanding == 3'd0);
  assign outstanding = r_outstanding;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_outstanding <= 3'd0;
    end else if (w_awHs && !w_bHs) begin
      r_outstanding <= r_outstanding + 3'd1;
    end else if (!w_awHs && w_bHs && (r_outstanding != 3'd0)) begin
      r_outstanding <= r_outstanding - 3'd1;
    end
  end
`else
  logic w_unusedB;

  assign w_unusedB   = BVALID_S ^ BREADY_S;
  assign w_creditOk  = 1'b1;
  assign w_underflow = 1'b0;
  assign outstanding = 3'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!fifo_rempty && w_creditOk) begin
          w_load      = 1'b1;
          w_stateNext = ISSUE;
        end
      end
      ISSUE: begin
        if (AWREADY_S) begin
          if (!fifo_rempty && w_creditOk) begin
            w_load = 1'b1;
          end else begin
            w_stateNext = IDLE;
          end
        end
      end
    endcase
  end

  // Gate with rst so the pop is dropped the instant reset asserts.
  assign fifo_rpop = w_load && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_payload <= 49'd0;
    end else if (w_load) begin
      r_payload <= fifo_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awErr <= 1'b0;
    end else if ((w_load && (fifo_rdata[1:0] == 2'b11)) || w_underflow) begin
      r_awErr <= 1'b1;
    end
  end

  assign aw_err    = r_awErr;
  assign AWVALID_S = (r_state == ISSUE);
  assign AWID_S    = r_payload[48:41];
  assign AWADDR_S  = r_payload[40:9];
  assign AWLEN_S   = r_payload[8:5];
  assign AWSIZE_S  = r_payload[4:2];
  assign AWBURST_S = r_payload[1:0];

endmodule

// File: tb/tb_aw_slave_issue.sv
// Self-checking bench for aw_slave_issue: the bench owns the upstream FIFO as a queue
// and predicts pops, slot contents, outstanding count and error flag transaction by transaction.
module tb_aw_slave_issue;

  localparam int MAXO = 4;

  logic        clk;
  logic        rst;
  logic        fifo_rempty;
  logic [48:0] fifo_rdata;
  logic        fifo_rpop;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic        BVALID_S;
  logic        BREADY_S;
  logic [2:0]  outstanding;
  logic        aw_err;

  int checks = 0;
  int errors = 0;

  logic [48:0] fifoQ[$];
  bit          mFull;
  logic [48:0] mSlot;
  int          mCount;
  bit          mErr;

  aw_slave_issue #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .fifo_rempty(fifo_rempty), .fifo_rdata(fifo_rdata), .fifo_rpop(fifo_rpop),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S), .AWSIZE_S(AWSIZE_S),
    .AWBURST_S(AWBURST_S), .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .outstanding(outstanding), .aw_err(aw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [48:0] makeEntry(input logic [7:0] id, input logic [31:0] addr,
                                            input logic [3:0] len, input logic [2:0] size,
                                            input logic [1:0] burst);
    return {id, addr, len, size, burst};
  endfunction

  function automatic logic [48:0] randEntry();
    logic [1:0] burst;
    burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    return makeEntry(8'($urandom), $urandom, 4'($urandom), 3'($urandom), burst);
  endfunction

  function automatic logic [48:0] awBus();
    return {AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S};
  endfunction

  // One clock cycle: drive at posedge+1, check at the falling edge, then advance the model.
  task automatic stepCycle(input bit ready, input bit bv, input bit br);
    bit credit;
    bit expPop;
    bit awHs;
    bit bHs;
    AWREADY_S   = ready;
    BVALID_S    = bv;
    BREADY_S    = br;
    fifo_rempty = (fifoQ.size() == 0);
    fifo_rdata  = (fifoQ.size() != 0) ? fifoQ[0] : 49'd0;
    #4;
`ifdef AW_SLAVE_OUTSTANDING_LIMIT_EN
    credit = (mCount + int'(mFull)) < MAXO;
`else
    credit = 1'b1;
`endif
    expPop = (fifoQ.size() != 0) && credit && (!mFull || ready);
    checkVal("rpop", 64'(fifo_rpop), 64'(expPop));
    checkVal("awvalid", 64'(AWVALID_S), 64'(mFull));
    checkVal("outstanding", 64'(outstanding), 64'(mCount));
    checkVal("aw_err", 64'(aw_err), 64'(mErr));
    if (mFull) checkVal("payload", 64'(awBus()), 64'(mSlot));

    awHs = mFull && ready;
    bHs  = bv && br;
`ifdef AW_SLAVE_OUTSTANDING_LIMIT_EN
    if (bHs && mCount == 0) mErr = 1'b1;
    mCount = mCount + int'(awHs) - int'(bHs);
    if (mCount < 0) mCount = 0;
`endif
    if (expPop) begin
      mSlot = fifoQ.pop_front();
      mFull = 1'b1;
      if (mSlot[1:0] == 2'b11) mErr = 1'b1;
    end else if (awHs) begin
      mFull = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    fifoQ.delete();
    mFull  = 1'b0;
    mSlot  = 49'd0;
    mCount = 0;
    mErr   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    AWREADY_S = 1'b0;
    BVALID_S = 1'b0;
    BREADY_S = 1'b0;
    modelReset();
    fifoQ.push_back(makeEntry(8'h12, 32'h1000_0040, 4'd3, 3'd2, 2'd1));
    fifo_rempty = 1'b0;
    fifo_rdata  = fifoQ[0];
    @(posedge clk);
    #1;
    checkVal("rst_rpop", 64'(fifo_rpop), 64'd0);
    checkVal("rst_awvalid", 64'(AWVALID_S), 64'd0);
    checkVal("rst_payload", 64'(awBus()), 64'd0);
    checkVal("rst_outstanding", 64'(outstanding), 64'd0);
    checkVal("rst_aw_err", 64'(aw_err), 64'd0);
    rst = 1'b0;

    // Single transaction with the slave always ready.
    for (int i = 0; i < 4; i++) stepCycle(1'b1, 1'b0, 1'b0);
    checkVal("single_id", 64'(mSlot[48:41]), 64'h12);

    // Three queued, slave stalls five cycles, then drains back-to-back.
    for (int i = 0; i < 3; i++) fifoQ.push_back(randEntry() & ~49'h3);
    for (int i = 0; i < 5; i++) stepCycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) stepCycle(1'b1, 1'b0, 1'b0);

    // B traffic, including possible underflow when the limit is built in.
    for (int i = 0; i < 6; i++) stepCycle(1'b1, 1'b1, 1'b1);

    // Illegal burst still issued.
    fifoQ.push_back(makeEntry(8'hA5, 32'hDEAD_BEE0, 4'd1, 3'd3, 2'b11));
    for (int i = 0; i < 3; i++) stepCycle(1'b1, 1'b0, 1'b0);

    // Reset mid-ISSUE while the slave stalls.
    fifoQ.push_back(randEntry());
    fifoQ.push_back(randEntry());
    for (int i = 0; i < 3; i++) stepCycle(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkVal("midrst_awvalid", 64'(AWVALID_S), 64'd0);
    checkVal("midrst_rpop", 64'(fifo_rpop), 64'd0);
    checkVal("midrst_outstanding", 64'(outstanding), 64'd0);
    checkVal("midrst_aw_err", 64'(aw_err), 64'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle(1'b1, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if (fifoQ.size() < 8 && $urandom_range(0, 9) < 4) fifoQ.push_back(randEntry());
      stepCycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
